addr_gen_param: RTL

Parametrised, programmable address generator for TTA memory-streaming actors. Produces a sequence of addresses `base + i*stride` (modulo 2^ADDR_W) for i = 0..last_idx, one address per consumer acknowledge. It supports one-shot and continuous (wrap) modes, abort, and per-sequence done pulses. It also keeps a legacy `status` flag so existing fixed 1024-entry, stride-1 users can move over with ADDR_W=10, base=0, stride=1, last_idx=1023.

---
 rtl/addr_gen_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/addr_gen_param.sv
// rtl/addr_gen_param.sv - programmable base+i*stride address generator with one-shot/wrap modes
module addr_gen_param #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              wrap_mode,
  input  logic              ack,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              status
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              status_q, status_d;
  logic              last_hit;

  // Compare before increment so a full-range sequence never overflows idx.
  assign last_hit = (idx_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      last_q   <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      last_q   <= last_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack && last_hit && !wrap_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    idx_d    = idx_q;
    base_d   = base_q;
    stride_d = stride_q;
    last_d   = last_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;
    status_d = status_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d   = base;
          stride_d = stride;
          last_d   = last_idx;
          wrap_d   = wrap_mode;
          addr_d   = base;
          idx_d    = '0;
          status_d = 1'b1;
        end
      end
      S_RUN: begin
        // Abort wins over a same-cycle ack: everything holds.
        if (!abort && ack) begin
          if (last_hit) begin
            done_d = 1'b1;
            if (wrap_q) begin
              addr_d = base_q;
              idx_d  = '0;
            end else begin
              status_d = 1'b0;
            end
          end else begin
            addr_d = addr_q + stride_q;
            idx_d  = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    addr   = addr_q;
    valid  = (state_q == S_RUN);
    busy   = (state_q == S_RUN);
    done   = done_q;
    status = status_q;
  end

endmodule
